// File: rtl/module_hamming_encoder_stream_if.sv
// Stream bundle for the Hamming encoder: data and injection positions in,
// registered codeword, check bits and handshake counter out.
interface module_hamming_encoder_stream_if #(
  parameter int DATA_W = 4,
  parameter int SECDED = 0,
  parameter int CNT_W  = 16
);
  function automatic int calc_p(input int dw);
    int p;
    p = 7;
    for (int k = 7; k >= 1; k--)
      if ((1 << k) >= dw + k + 1) p = k;
    return p;
  endfunction

  localparam int P  = calc_p(DATA_W);
  localparam int N  = DATA_W + P + SECDED;
  localparam int IW = $clog2(N + 1);
  localparam int PW = P + SECDED;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [IW-1:0]     inject_pos;
  logic [IW-1:0]     inject_pos2;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      out_code;
  logic [PW-1:0]     out_parity;
  logic [CNT_W-1:0]  word_count;

  modport master (
    output in_valid, in_data, inject_pos, inject_pos2, out_ready,
    input  in_ready, out_valid, out_code, out_parity, word_count
  );

  modport slave (
    input  in_valid, in_data, inject_pos, inject_pos2, out_ready,
    output in_ready, out_valid, out_code, out_parity, word_count
  );
endinterface

// File: rtl/module_hamming_encoder_stream.sv
// Parametrised Hamming / SECDED encoder with a one-entry registered output
// stage, valid/ready streaming and per-word single/double bit-flip injection.
module module_hamming_encoder_stream #(
  parameter int DATA_W = 4,
  parameter int SECDED = 0,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic rst_n,
  module_hamming_encoder_stream_if.slave stream
);
  function automatic int calc_p(input int dw);
    int p;
    p = 7;
    for (int k = 7; k >= 1; k--)
      if ((1 << k) >= dw + k + 1) p = k;
    return p;
  endfunction

  localparam int P  = calc_p(DATA_W);
  localparam int NH = DATA_W + P;
  localparam int N  = NH + SECDED;
  localparam int IW = $clog2(N + 1);
  localparam int PW = P + SECDED;

  if (DATA_W < 1 || DATA_W > 57) begin : g_bad_data_w
    $error("DATA_W must lie in 1..57");
  end
  if (SECDED != 0 && SECDED != 1) begin : g_bad_secded
    $error("SECDED must be 0 or 1");
  end

  function automatic bit is_pow2(input int v);
    return (v & (v - 1)) == 0;
  endfunction

  // Data bits fill the non power-of-two positions in ascending order.
  function automatic logic [NH-1:0] place_data(input logic [DATA_W-1:0] d);
    int di;
    place_data = '0;
    di = 0;
    for (int pos = 1; pos <= NH; pos++) begin
      if (!is_pow2(pos)) begin
        place_data[pos-1] = d[di];
        di = di + 1;
      end
    end
  endfunction

  function automatic logic [P-1:0] check_bits(input logic [NH-1:0] h);
    check_bits = '0;
    for (int j = 0; j < P; j++)
      for (int pos = 1; pos <= NH; pos++)
        if (((pos >> j) & 1) == 1 && !is_pow2(pos))
          check_bits[j] = check_bits[j] ^ h[pos-1];
  endfunction

  // Out-of-range positions (0 or > N) produce an empty mask.
  function automatic logic [N-1:0] flip_mask(input logic [IW-1:0] pos);
    flip_mask = '0;
    for (int k = 1; k <= N; k++)
      if (int'(pos) == k) flip_mask[k-1] = 1'b1;
  endfunction

  logic [NH-1:0]    ham_p0;
  logic [P-1:0]     chk_p0;
  logic [N-1:0]     code_p0;
  logic [N-1:0]     flip_p0;
  logic [PW-1:0]    par_p0;

  logic             vld_p1;
  logic [N-1:0]     code_p1;
  logic [PW-1:0]    par_p1;
  logic [CNT_W-1:0] word_cnt;

  logic             in_xfer;
  logic             out_xfer;

  // ---- stage p0: combinational encode of the presented word ----
  always_comb begin
    ham_p0 = place_data(stream.in_data);
    chk_p0 = check_bits(ham_p0);
    for (int j = 0; j < P; j++) ham_p0[(1 << j) - 1] = chk_p0[j];
    code_p0 = '0;
    code_p0[NH-1:0] = ham_p0;
    par_p0 = '0;
    par_p0[P-1:0] = chk_p0;
    if (SECDED != 0) begin
      code_p0[N-1] = ^ham_p0;
      par_p0[PW-1] = ^ham_p0;
    end
    // XOR of the two masks makes equal positions cancel.
    flip_p0 = flip_mask(stream.inject_pos) ^ flip_mask(stream.inject_pos2);
  end

  assign in_xfer  = stream.in_valid && stream.in_ready;
  assign out_xfer = vld_p1 && stream.out_ready;

  // ---- stage p1: one-entry output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      code_p1  <= '0;
      par_p1   <= '0;
      word_cnt <= '0;
    end else begin
      if (in_xfer) begin
        vld_p1  <= 1'b1;
        code_p1 <= code_p0 ^ flip_p0;
        par_p1  <= par_p0;
      end else if (out_xfer) begin
        vld_p1  <= 1'b0;
      end
      if (out_xfer) word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  assign stream.in_ready   = !vld_p1 || stream.out_ready;
  assign stream.out_valid  = vld_p1;
  assign stream.out_code   = code_p1;
  assign stream.out_parity = par_p1;
  assign stream.word_count = word_cnt;

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    vld_p1 && !stream.out_ready |=> vld_p1 && $stable(code_p1) && $stable(par_p1));
endmodule

// File: tb/tb_module_hamming_encoder_stream.sv
// Four encoder configurations driven in lockstep from shared stimulus and
// checked against a positional Hamming model plus directed vector tables.
module tb_module_hamming_encoder_stream;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [3:0] inj1 = 4'd0;
  logic [3:0] inj2 = 4'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // a: 4-bit plain, b: 4-bit SECDED with 4-bit counter, c: 8-bit plain, d: 8-bit SECDED
  module_hamming_encoder_stream_if #(.DATA_W(4), .SECDED(0), .CNT_W(16)) if_a ();
  module_hamming_encoder_stream_if #(.DATA_W(4), .SECDED(1), .CNT_W(4))  if_b ();
  module_hamming_encoder_stream_if #(.DATA_W(8), .SECDED(0), .CNT_W(16)) if_c ();
  module_hamming_encoder_stream_if #(.DATA_W(8), .SECDED(1), .CNT_W(8))  if_d ();

  module_hamming_encoder_stream #(.DATA_W(4), .SECDED(0), .CNT_W(16)) u_a (.clk(clk), .rst_n(rst_n), .stream(if_a));
  module_hamming_encoder_stream #(.DATA_W(4), .SECDED(1), .CNT_W(4))  u_b (.clk(clk), .rst_n(rst_n), .stream(if_b));
  module_hamming_encoder_stream #(.DATA_W(8), .SECDED(0), .CNT_W(16)) u_c (.clk(clk), .rst_n(rst_n), .stream(if_c));
  module_hamming_encoder_stream #(.DATA_W(8), .SECDED(1), .CNT_W(8))  u_d (.clk(clk), .rst_n(rst_n), .stream(if_d));

  // Instance a has a 3-bit injection port and only sees the low bits.
  assign if_a.in_valid = in_valid;  assign if_a.out_ready = out_ready;
  assign if_a.in_data = in_data[3:0];
  assign if_a.inject_pos = inj1[2:0]; assign if_a.inject_pos2 = inj2[2:0];
  assign if_b.in_valid = in_valid;  assign if_b.out_ready = out_ready;
  assign if_b.in_data = in_data[3:0];
  assign if_b.inject_pos = inj1;    assign if_b.inject_pos2 = inj2;
  assign if_c.in_valid = in_valid;  assign if_c.out_ready = out_ready;
  assign if_c.in_data = in_data;
  assign if_c.inject_pos = inj1;    assign if_c.inject_pos2 = inj2;
  assign if_d.in_valid = in_valid;  assign if_d.out_ready = out_ready;
  assign if_d.in_data = in_data;
  assign if_d.inject_pos = inj1;    assign if_d.inject_pos2 = inj2;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  // Reference codeword: lay out data, then choose each check bit so that the
  // XOR over all positions having bit j set comes out zero.
  function automatic logic [63:0] ref_code(input int dw, input int sec, input logic [63:0] d,
                                          input int pa, input int pb, output logic [63:0] par);
    int p, nh, n, iw, di;
    logic [63:0] cw;
    logic c;
    p = calc_p(dw);
    nh = dw + p;
    n = nh + sec;
    iw = 0;
    while ((1 << iw) < n + 1) iw++;
    cw = '0;
    di = 0;
    for (int pos = 1; pos <= nh; pos++)
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = d[di];
        di++;
      end
    par = '0;
    for (int j = 0; j < p; j++) begin
      c = 1'b0;
      for (int pos = 1; pos <= nh; pos++)
        if ((pos & (1 << j)) != 0) c = c ^ cw[pos-1];
      cw[(1 << j) - 1] = c;
      par[j] = c;
    end
    if (sec != 0) begin
      c = ^cw;
      cw[n-1] = c;
      par[p] = c;
    end
    pa = pa & ((1 << iw) - 1);
    pb = pb & ((1 << iw) - 1);
    if (pa >= 1 && pa <= n) cw[pa-1] = ~cw[pa-1];
    if (pb >= 1 && pb <= n) cw[pb-1] = ~cw[pb-1];
    return cw;
  endfunction

  typedef struct { logic [7:0] d; logic [3:0] a; logic [3:0] b; } txn_t;
  txn_t q[$];
  int mcnt = 0;

  task automatic check_inst(input string nm, input int dw, input int sec, input int cw,
                            input logic vld, input logic rdy, input logic [63:0] code,
                            input logic [63:0] par, input logic [63:0] wc);
    logic [63:0] ecode, epar;
    int nh, s;
    chk({nm, "_out_valid"}, 64'(vld), 64'(q.size() != 0));
    chk({nm, "_in_ready"}, 64'(rdy), 64'(q.size() == 0 || out_ready));
    chk({nm, "_word_count"}, wc, 64'(mcnt) & ((64'd1 << cw) - 64'd1));
    if (q.size() != 0) begin
      ecode = ref_code(dw, sec, 64'(q[0].d) & ((64'd1 << dw) - 64'd1),
                       int'(q[0].a), int'(q[0].b), epar);
      chk({nm, "_out_code"}, code, ecode);
      chk({nm, "_out_parity"}, par, epar);
      if (q[0].a == 4'd0 && q[0].b == 4'd0) begin
        nh = dw + calc_p(dw);
        s = 0;
        for (int pos = 1; pos <= nh; pos++) if (code[pos-1]) s = s ^ pos;
        chk({nm, "_syndrome"}, 64'(s), 64'd0);
        if (sec != 0) chk({nm, "_overall_parity"}, 64'(^code), 64'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    bit ixf, oxf;
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
    end else begin
      check_inst("a", 4, 0, 16, if_a.out_valid, if_a.in_ready, 64'(if_a.out_code), 64'(if_a.out_parity), 64'(if_a.word_count));
      check_inst("b", 4, 1, 4,  if_b.out_valid, if_b.in_ready, 64'(if_b.out_code), 64'(if_b.out_parity), 64'(if_b.word_count));
      check_inst("c", 8, 0, 16, if_c.out_valid, if_c.in_ready, 64'(if_c.out_code), 64'(if_c.out_parity), 64'(if_c.word_count));
      check_inst("d", 8, 1, 8,  if_d.out_valid, if_d.in_ready, 64'(if_d.out_code), 64'(if_d.out_parity), 64'(if_d.word_count));
      ixf = in_valid && (q.size() == 0 || out_ready);
      oxf = (q.size() != 0) && out_ready;
      if (oxf) begin
        void'(q.pop_front());
        mcnt++;
      end
      if (ixf) q.push_back('{in_data, inj1, inj2});
    end
  end

  typedef struct {
    logic [3:0] d; logic [3:0] a; logic [3:0] b;
    logic [6:0] c7; logic [2:0] p3; logic [7:0] c8; logic [3:0] p4;
  } vec_t;
  vec_t tv [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    inj1 = 4'd0;
    inj2 = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, cyc;
    bit acc;
    // data, inj1, inj2, code(a), parity(a), code(b), parity(b)
    tv[0]  = '{4'b1011, 4'd0,  4'd0, 7'h55, 3'b001, 8'h55, 4'b0001};
    tv[1]  = '{4'b0001, 4'd0,  4'd0, 7'h07, 3'b011, 8'h87, 4'b1011};
    tv[2]  = '{4'b0000, 4'd0,  4'd0, 7'h00, 3'b000, 8'h00, 4'b0000};
    tv[3]  = '{4'b1111, 4'd0,  4'd0, 7'h7F, 3'b111, 8'hFF, 4'b1111};
    tv[4]  = '{4'b0010, 4'd0,  4'd0, 7'h19, 3'b101, 8'h99, 4'b1101};
    tv[5]  = '{4'b0100, 4'd0,  4'd0, 7'h2A, 3'b110, 8'hAA, 4'b1110};
    tv[6]  = '{4'b1000, 4'd0,  4'd0, 7'h4B, 3'b111, 8'h4B, 4'b0111};
    tv[7]  = '{4'b1011, 4'd3,  4'd0, 7'h51, 3'b001, 8'h51, 4'b0001};
    tv[8]  = '{4'b1011, 4'd3,  4'd3, 7'h55, 3'b001, 8'h55, 4'b0001};
    tv[9]  = '{4'b1011, 4'd9,  4'd0, 7'h54, 3'b001, 8'h55, 4'b0001};
    tv[10] = '{4'b1011, 4'd8,  4'd0, 7'h55, 3'b001, 8'hD5, 4'b0001};
    tv[11] = '{4'b1011, 4'd2,  4'd7, 7'h17, 3'b001, 8'h17, 4'b0001};
    tv[12] = '{4'b1011, 4'd15, 4'd0, 7'h15, 3'b001, 8'h55, 4'b0001};
    tv[13] = '{4'b0001, 4'd1,  4'd8, 7'h06, 3'b011, 8'h06, 4'b1011};

    do_reset();
    chk("rst_out_valid", if_a.out_valid, 1'b0);
    chk("rst_out_code", if_d.out_code, 13'h0);
    chk("rst_out_parity", if_d.out_parity, 5'h0);
    chk("rst_word_count", if_a.word_count, 16'h0);
    chk("rst_in_ready", if_a.in_ready, 1'b1);

    for (int i = 0; i < 14; i++) begin
      in_data = {4'b0000, tv[i].d};
      inj1 = tv[i].a;
      inj2 = tv[i].b;
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      inj1 = 4'd0;
      inj2 = 4'd0;
      chk($sformatf("tv%0d_code_a", i), if_a.out_code, tv[i].c7);
      chk($sformatf("tv%0d_par_a", i), if_a.out_parity, tv[i].p3);
      chk($sformatf("tv%0d_code_b", i), if_b.out_code, tv[i].c8);
      chk($sformatf("tv%0d_par_b", i), if_b.out_parity, tv[i].p4);
      chk($sformatf("tv%0d_valid", i), if_a.out_valid, 1'b1);
      chk($sformatf("tv%0d_count", i), if_a.word_count, 16'(i));
    end
    tick();
    chk("tv_final_count", if_a.word_count, 16'd14);
    chk("tv_drained", if_a.out_valid, 1'b0);

    // Backpressure: one word held for 5 cycles while new data is offered.
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h0B;
    tick();
    in_data = 8'h00;
    inj1 = 4'd5;
    repeat (5) begin
      chk("bp_in_ready", if_a.in_ready, 1'b0);
      chk("bp_valid", if_a.out_valid, 1'b1);
      chk("bp_code_stable", if_a.out_code, 7'h55);
      tick();
    end
    inj1 = 4'd0;
    out_ready = 1'b1;
    in_data = 8'h01; tick();
    chk("bp_b2b_code0", if_a.out_code, 7'h07);
    in_data = 8'h0F; tick();
    chk("bp_b2b_code1", if_a.out_code, 7'h7F);
    in_data = 8'h02; tick();
    chk("bp_b2b_code2", if_a.out_code, 7'h19);
    in_valid = 1'b0;
    tick();
    chk("bp_word_count", if_a.word_count, 16'd4);
    chk("bp_drained", if_a.out_valid, 1'b0);

    // Asynchronous reset while a word is held.
    in_valid = 1'b1;
    in_data = 8'h0B;
    out_ready = 1'b0;
    tick();
    chk("ar_held", if_a.out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid_a", if_a.out_valid, 1'b0);
    chk("ar_valid_d", if_d.out_valid, 1'b0);
    chk("ar_count_a", if_a.word_count, 16'd0);
    chk("ar_code_a", if_a.out_code, 7'h00);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    #3 rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("ar_no_emit", if_d.out_valid, 1'b0);
    end

    // Counter wrap on the 4-bit counter.
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      in_data = 8'(k * 7);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_count_b", if_b.word_count, 4'd1);
    chk("wrap_count_a", if_a.word_count, 16'd17);

    // Randomised traffic with injection.
    for (int k = 0; k < 600; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      inj1 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      inj2 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      tick();
    end

    // Every 8-bit value (and every low nibble) streamed with random valid/ready.
    inj1 = 4'd0;
    inj2 = 4'd0;
    v = 0;
    cyc = 0;
    while (v < 256 && cyc < 4000) begin
      in_data = 8'(v);
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && if_c.in_ready;
      @(posedge clk);
      #1;
      if (acc) v++;
      cyc++;
    end
    chk("exhaustive_words_accepted", 64'(v), 64'd256);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("exhaustive_drained", if_d.out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
